// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state encodings,
// the NOP instruction word and the register-address width.
package pipe_ctrl_pkg;

    localparam int          REG_AW   = 5;
    localparam logic [31:0] NOP_INSN = 32'h00000013;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_BUSY  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use hazard compare: the instruction in ID reads a register that the
// load currently in id_ex has not yet written back.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    output logic              load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit    = id_rs1_used_i && (id_rs1_addr_i == ex_rd_addr_i);
    assign rs2_hit    = id_rs2_used_i && (id_rs2_addr_i == ex_rd_addr_i);
    // x0 is hard-wired to zero, so a load targeting it can never create a hazard
    assign load_use_o = ex_load_i && (ex_rd_addr_i != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer for the 3-stage core: arbitrates redirects, load-use
// stalls, multi-cycle EX holds and debug halt; counts stall cycles.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int JUMP_FLUSH   = 1,
    parameter int BUSY_TIMEOUT = 1023,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [31:0]       jump_addr_i,
    input  logic              ex_busy_i,
    input  logic              ex_load_i,
    input  logic [REG_AW-1:0] ex_rd_addr_i,
    input  logic [REG_AW-1:0] id_rs1_addr_i,
    input  logic [REG_AW-1:0] id_rs2_addr_i,
    input  logic              id_rs1_used_i,
    input  logic              id_rs2_used_i,
    input  logic              halt_req_i,
    output logic              pc_jump_en_o,
    output logic [31:0]       pc_jump_addr_o,
    output logic              pc_hold_o,
    output logic              if_id_hold_o,
    output logic              if_id_flush_o,
    output logic              id_ex_hold_o,
    output logic              id_ex_flush_o,
    output logic              halted_o,
    output logic              err_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int FL_W = 3;
    localparam int BZ_W = $clog2(BUSY_TIMEOUT + 1);

    state_e          state_q;
    state_e          state_d;
    logic [FL_W-1:0] flush_cnt_q;
    logic [BZ_W-1:0] busy_cnt_q;
    logic [BZ_W-1:0] busy_cnt_inc;
    logic            load_use;

    logic jmp;
    logic pc_hold;
    logic if_id_hold;
    logic if_id_flush;
    logic id_ex_hold;
    logic id_ex_flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    pipe_ctrl_hazard_detect u_hazard (
        .ex_load_i     (ex_load_i),
        .ex_rd_addr_i  (ex_rd_addr_i),
        .id_rs1_addr_i (id_rs1_addr_i),
        .id_rs2_addr_i (id_rs2_addr_i),
        .id_rs1_used_i (id_rs1_used_i),
        .id_rs2_used_i (id_rs2_used_i),
        .load_use_o    (load_use)
    );

    always_comb begin
        state_d     = state_q;
        jmp         = 1'b0;
        pc_hold     = 1'b0;
        if_id_hold  = 1'b0;
        if_id_flush = 1'b0;
        id_ex_hold  = 1'b0;
        id_ex_flush = 1'b0;
        case (state_q)
            // BUSY falls back to the RUN rules in the cycle ex_busy_i drops
            ST_RUN, ST_BUSY: begin
                if (ex_busy_i) begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    id_ex_hold = 1'b1;
                    state_d    = ST_BUSY;
                end else if (jump_en_i) begin
                    jmp         = 1'b1;
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_FLUSH;
                end else if (load_use) begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_RUN;
                end else if (halt_req_i) begin
                    pc_hold     = 1'b1;
                    if_id_hold  = 1'b1;
                    id_ex_flush = 1'b1;
                    state_d     = ST_HALT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
                if (flush_cnt_q <= FL_W'(1)) state_d = ST_RUN;
            end
            ST_HALT: begin
                pc_hold    = 1'b1;
                if_id_hold = 1'b1;
                id_ex_hold = 1'b1;
                if (!halt_req_i) state_d = ST_RUN;
            end
        endcase
    end

    // Reset forces every control low; a flush always overrides a hold on the same stage
    assign pc_jump_en_o   = rst & jmp;
    assign pc_jump_addr_o = (rst & jmp) ? jump_addr_i : 32'h0;
    assign pc_hold_o      = rst & pc_hold;
    assign if_id_flush_o  = rst & if_id_flush;
    assign if_id_hold_o   = rst & if_id_hold & ~if_id_flush;
    assign id_ex_flush_o  = rst & id_ex_flush;
    assign id_ex_hold_o   = rst & id_ex_hold & ~id_ex_flush;

    assign busy_cnt_inc = (busy_cnt_q == BZ_W'(BUSY_TIMEOUT)) ? busy_cnt_q
                                                              : busy_cnt_q + BZ_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= '0;
            busy_cnt_q  <= '0;
            halted_o    <= 1'b0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            state_q  <= state_d;
            halted_o <= (state_d == ST_HALT);

            if (jmp) begin
                flush_cnt_q <= FL_W'(JUMP_FLUSH);
            end else if (state_q == ST_FLUSH && flush_cnt_q != '0) begin
                flush_cnt_q <= flush_cnt_q - FL_W'(1);
            end

            // Consecutive busy cycles; err_o is sticky until reset
            if (state_d == ST_BUSY) begin
                busy_cnt_q <= busy_cnt_inc;
                if (busy_cnt_inc == BZ_W'(BUSY_TIMEOUT)) err_o <= 1'b1;
            end else begin
                busy_cnt_q <= '0;
            end

            if (pc_hold_o) stall_cnt_o <= sat_inc(stall_cnt_o);
        end
    end

endmodule
